// File: rtl/servant_dbus_xbar.sv
// Address-decoded Wishbone crossbar from the serv data bus to NUM_SLAVES slaves.
// Optional error capture registers are enabled by SERVANT_DBUS_XBAR_ERRCAP_EN.
module servant_dbus_xbar #(
    parameter int unsigned NUM_SLAVES   = 4,
    parameter int unsigned SEL_MSB      = 31,
    parameter int unsigned SEL_LSB      = 30,
    parameter logic [31:0] SLV_ACK_MASK = 32'h0000_0001,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
`ifdef SERVANT_DBUS_XBAR_ERRCAP_EN
    input  logic                     i_err_clr,
    output logic                     o_err_flag,
    output logic [31:0]              o_err_adr,
`endif
    input  logic [31:0]              i_wb_cpu_adr,
    input  logic [31:0]              i_wb_cpu_dat,
    input  logic [3:0]               i_wb_cpu_sel,
    input  logic                     i_wb_cpu_we,
    input  logic                     i_wb_cpu_cyc,
    output logic [31:0]              o_wb_cpu_rdt,
    output logic                     o_wb_cpu_ack,
    output logic                     o_wb_cpu_err,
    output logic [31:0]              o_wb_slv_adr,
    output logic [31:0]              o_wb_slv_dat,
    output logic [3:0]               o_wb_slv_sel,
    output logic                     o_wb_slv_we,
    output logic [NUM_SLAVES-1:0]    o_wb_slv_cyc,
    input  logic [32*NUM_SLAVES-1:0] i_wb_slv_rdt,
    input  logic [NUM_SLAVES-1:0]    i_wb_slv_ack
);

    localparam int unsigned SelW = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [SelW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdt_q, rdt_d;
    logic            err_q, err_d;

    logic [SelW-1:0] adr_idx;
    logic            sel_ack;
    logic            sel_self;
    logic [31:0]     sel_rdt;
    logic            timeout_hit;

    assign adr_idx = i_wb_cpu_adr[SEL_MSB:SEL_LSB];

    // Per-slave view of the currently latched index.
    always_comb begin
        sel_ack  = 1'b0;
        sel_self = 1'b0;
        sel_rdt  = '0;
        for (int n = 0; n < NUM_SLAVES; n++) begin
            if (idx_q == SelW'(n)) begin
                sel_ack  = i_wb_slv_ack[n];
                sel_self = SLV_ACK_MASK[n];
                sel_rdt  = i_wb_slv_rdt[32*n +: 32];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rdt_d   = rdt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (i_wb_cpu_cyc) begin
                    idx_d = adr_idx;
                    cnt_d = '0;
                    if (32'(adr_idx) < NUM_SLAVES) begin
                        state_d = StActive;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        rdt_d   = '0;
                    end
                end
            end
            StActive: begin
                cnt_d = cnt_q + 1'b1;
                if (!i_wb_cpu_cyc) begin
                    // Master abandoned the cycle: drop it silently.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (!sel_self || sel_ack) begin
                    state_d = StDone;
                    rdt_d   = sel_rdt;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = StDone;
                    rdt_d   = '0;
                    err_d   = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdt_q   <= rdt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        o_wb_slv_cyc = '0;
        if (state_q == StActive) begin
            for (int n = 0; n < NUM_SLAVES; n++) begin
                o_wb_slv_cyc[n] = (idx_q == SelW'(n));
            end
        end
    end

    assign o_wb_cpu_ack = (state_q == StDone);
    assign o_wb_cpu_err = err_q;
    assign o_wb_cpu_rdt = rdt_q;
    assign o_wb_slv_adr = i_wb_cpu_adr;
    assign o_wb_slv_dat = i_wb_cpu_dat;
    assign o_wb_slv_sel = i_wb_cpu_sel;
    assign o_wb_slv_we  = i_wb_cpu_we;

`ifdef SERVANT_DBUS_XBAR_ERRCAP_EN
    logic        err_flag_q, err_flag_d;
    logic [31:0] err_adr_q, err_adr_d;
    logic        err_entry;

    assign err_entry = (state_d == StDone) && err_d;

    always_comb begin
        err_flag_d = err_flag_q;
        err_adr_d  = err_adr_q;
        if (i_err_clr) begin
            err_flag_d = 1'b0;
        end
        if (err_entry) begin
            err_flag_d = 1'b1;
            err_adr_d  = i_wb_cpu_adr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_flag_q <= 1'b0;
            err_adr_q  <= '0;
        end else begin
            err_flag_q <= err_flag_d;
            err_adr_q  <= err_adr_d;
        end
    end

    assign o_err_flag = err_flag_q;
    assign o_err_adr  = err_adr_q;
`endif

endmodule
